// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60Hz timing constants shared by vga_sync_gen and anim_gen.
// Holds the coordinate type, default porch/sync widths and derived windows.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Clock divider producing the one-clk pixel-rate strobe.
// Ports: clk, reset (async, active low) in; p_tick out.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;
    logic [W-1:0] div_nxt;

    assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + W'(1);

    // p_tick is registered against the next count so it is high
    // exactly while div_cnt sits at its last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            p_tick  <= (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel cursor, hsync/vsync and video_on, all registered.
// Ports: clk, reset (async, active low) in; hsync, vsync, video_on, p_tick,
// x_control[9:0], y_control[9:0] out; frame_tick out with VGA_FRAME_TICK_EN.
import vga_timing_pkg::*;

module vga_sync_gen #(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x_control,
    output logic [9:0] y_control
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t HT_M1    = coord_t'(HT - 1);
    localparam coord_t VT_M1    = coord_t'(VT - 1);
    localparam coord_t HD       = coord_t'(H_DISPLAY);
    localparam coord_t VD       = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t x_nxt;
    coord_t y_nxt;
    logic   x_wrap;
    logic   y_wrap;

    pixel_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .p_tick(p_tick)
    );

    assign x_wrap = (x_control == HT_M1);
    assign y_wrap = (y_control == VT_M1);

    always_comb begin
        x_nxt = x_control;
        y_nxt = y_control;
        if (p_tick) begin
            x_nxt = x_wrap ? '0 : x_control + 10'd1;
            if (x_wrap) begin
                y_nxt = y_wrap ? '0 : y_control + 10'd1;
            end
        end
    end

    // Decodes use the next-state cursor so they land on the same edge
    // as x/y; video_on therefore stays 0 until the first p_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_control <= '0;
            y_control <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            video_on  <= 1'b0;
        end else if (p_tick) begin
            x_control <= x_nxt;
            y_control <= y_nxt;
            hsync     <= !in_window(x_nxt, HS_START, HS_END);
            vsync     <= !in_window(y_nxt, VS_START, VS_END);
            video_on  <= (x_nxt < HD) && (y_nxt < VD);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= p_tick && x_wrap && y_wrap;
        end
    end
`endif

endmodule
